pc_sequencer: RTL and testbench

//   Owns the program counter and drives instruction fetch for the RISC core.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer_add4.sv | 11 +
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        HALT = 2'd3
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_add4.sv
// Sequential-PC incrementer: sum = addr + 4, wrapping modulo 2^ADDR_W.
module add4 #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] sum
);

    assign sum = addr + ADDR_W'(4);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer between imem and decode.
// Optional macro PC_ALIGN_CHECK_EN: misaligned taken branch halts and flags align_err.
//
// state | meaning
// IDLE  | first cycle after reset release
// REQ   | imem_req high at pc, waiting for imem_ack
// EXEC  | instruction at pc issued to decode (instr_valid)
// HALT  | core halted, left only through reset
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic              halted,
    output logic [31:0]       fetch_count,
    output logic              align_err
);

    pc_state_t         state, state_nxt;
    logic              br_misalign;
    logic              exec_exit;
    logic              exec_advance;
    logic [ADDR_W-1:0] br_load;

`ifdef PC_ALIGN_CHECK_EN
    assign br_misalign = (br_target[1:0] != 2'b00);
`else
    assign br_misalign = 1'b0;
`endif

    // Low bits are cleared on load; with the check enabled a misaligned
    // target never reaches the load, so the mask only matters without it.
    assign br_load      = br_target & ~ADDR_W'(3);
    assign exec_exit    = (state == EXEC) && (halt || !stall);
    assign exec_advance = (state == EXEC) && !halt && !stall;

    add4 #(.ADDR_W(ADDR_W)) u_add4 (
        .addr (pc),
        .sum  (pc_plus4)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (imem_ack) state_nxt = EXEC;
            EXEC: begin
                if (halt) begin
                    state_nxt = HALT;
                end else if (stall) begin
                    state_nxt = EXEC;
                end else if (br_taken && br_misalign) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = REQ;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            REQ:     imem_req    = 1'b1;
            EXEC:    instr_valid = 1'b1;
            HALT:    halted      = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            fetch_count <= 32'd0;
            align_err   <= 1'b0;
        end else begin
            if (exec_exit) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (exec_advance) begin
                if (br_taken) begin
                    if (br_misalign) begin
                        align_err <= 1'b1;
                    end else begin
                        pc <= br_load;
                    end
                end else begin
                    pc <= pc_plus4;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses are queued by
// the stimulus and popped by a monitor on every accepted imem handshake.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Primary DUT, RESET_PC = 0
    logic        rst, stall, halt, br_taken, imem_ack;
    logic [31:0] br_target;
    logic        imem_req, instr_valid, halted, align_err;
    logic [31:0] imem_addr, pc, pc_plus4, fetch_count;

    // Wrap DUT, RESET_PC = FFFF_FFFC
    logic        w_rst, w_stall, w_halt, w_br_taken, w_imem_ack;
    logic [31:0] w_br_target;
    logic        w_imem_req, w_instr_valid, w_halted, w_align_err;
    logic [31:0] w_imem_addr, w_pc, w_pc_plus4, w_fetch_count;

    int          checks = 0;
    int          fails  = 0;
    int          ack_delay = 0;
    int          a_wait = 0;
    int          w_wait = 0;
    bit          w_done = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_w[$];

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .halted(halted), .fetch_count(fetch_count), .align_err(align_err)
    );

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(w_rst), .stall(w_stall), .halt(w_halt),
        .br_taken(w_br_taken), .br_target(w_br_target),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack),
        .pc(w_pc), .pc_plus4(w_pc_plus4), .instr_valid(w_instr_valid),
        .halted(w_halted), .fetch_count(w_fetch_count), .align_err(w_align_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // imem models: ack after the configured number of waiting cycles
    always @(negedge clk) begin
        if (!rst || !imem_req) begin
            imem_ack = 1'b0;
            a_wait   = 0;
        end else begin
            imem_ack = (a_wait >= ack_delay);
            a_wait++;
        end
    end

    always @(negedge clk) begin
        if (!w_rst || !w_imem_req) begin
            w_imem_ack = 1'b0;
            w_wait     = 0;
        end else begin
            w_imem_ack = (w_wait >= 4);
            w_wait++;
        end
    end

    // Monitor: each accepted fetch is compared against the scoreboard
    always begin
        @(negedge clk);
        #1;
        if (rst && imem_req && imem_ack) begin
            if (q_a.size() == 0) chk("fetch_unexpected", imem_addr, 32'hDEAD_BEEF);
            else chk("fetch_addr", imem_addr, q_a.pop_front());
        end
        if (w_rst && w_imem_req && w_imem_ack) begin
            if (q_w.size() == 0) chk("w_fetch_unexpected", w_imem_addr, 32'hDEAD_BEEF);
            else chk("w_fetch_addr", w_imem_addr, q_w.pop_front());
        end
    end

    task automatic wait_exec(input logic [31:0] addr);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (instr_valid && pc == addr) found = 1;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL wait_exec: pc=%h valid=%b, required EXEC at %h", pc, instr_valid, addr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Wrap DUT: FFFF_FFFC then 0, each fetch acked after 5 request cycles
    initial begin
        int n;
        bit found;
        w_rst = 1'b0; w_stall = 1'b0; w_halt = 1'b0;
        w_br_taken = 1'b0; w_br_target = 32'h0;
        q_w.push_back(32'hFFFF_FFFC);
        q_w.push_back(32'h0000_0000);
        @(negedge clk);
        w_rst = 1'b1;
        for (int i = 0; i < 10 && !w_imem_req; i++) @(negedge clk);
        n = 0;
        while (w_imem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("wrap_req_hold_cycles", n, 5);
        chk("wrap_exec_valid", w_instr_valid, 1);
        chk("wrap_pc_plus4", w_pc_plus4, 32'h0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (w_instr_valid && w_pc == 32'h0) found = 1;
        end
        chk("wrap_second_exec_found", found, 1);
        w_halt = 1'b1;
        @(negedge clk);
        w_halt = 1'b0;
        chk("wrap_halted", w_halted, 1);
        chk("wrap_fetch_count", w_fetch_count, 2);
        w_done = 1;
    end

    initial begin
        int nv;
        rst = 1'b0; stall = 1'b0; halt = 1'b0;
        br_taken = 1'b0; br_target = 32'h0;
        #2;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fetch_count", fetch_count, 0);
        chk("rst_align_err", align_err, 0);

        // Sequential fetches, 1-cycle ack
        q_a.push_back(32'h0); q_a.push_back(32'h4); q_a.push_back(32'h8);
        q_a.push_back(32'hC); q_a.push_back(32'h10);
        @(negedge clk);
        rst = 1'b1;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            nv += int'(instr_valid);
        end
        chk("seq_valid_per_8_cycles", nv, 4);
        chk("seq_pc_after_8", pc, 32'hC);
        wait_exec(32'h10);
        chk("seq_fetch_count", fetch_count, 4);

        // Branch taken at pc=8
        do_reset();
        q_a.push_back(32'h0); q_a.push_back(32'h4); q_a.push_back(32'h8);
        q_a.push_back(32'h40); q_a.push_back(32'h44);
        wait_exec(32'h8);
        br_taken = 1'b1; br_target = 32'h40;
        @(negedge clk);
        br_taken = 1'b0;
        chk("br_req_addr", imem_addr, 32'h40);
        wait_exec(32'h44);
        chk("br_fetch_count", fetch_count, 4);

        // Stall, stall+branch, halt+branch
        do_reset();
        q_a.push_back(32'h0); q_a.push_back(32'h4);
        wait_exec(32'h4);
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_pc", pc, 32'h4);
            chk("stall_valid", instr_valid, 1);
            chk("stall_count", fetch_count, 1);
        end
        br_taken = 1'b1; br_target = 32'h80;
        @(negedge clk);
        chk("stall_br_pc", pc, 32'h4);
        chk("stall_br_valid", instr_valid, 1);
        chk("stall_br_req", imem_req, 0);
        stall = 1'b0; halt = 1'b1;
        @(negedge clk);
        halt = 1'b0; br_taken = 1'b0;
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 32'h4);
        chk("halt_valid", instr_valid, 0);
        chk("halt_count", fetch_count, 2);
        repeat (3) @(negedge clk);
        chk("halt_sticky", halted, 1);
        chk("halt_no_req", imem_req, 0);

        // Misaligned branch target
        do_reset();
        chk("reset_clears_halted", halted, 0);
        q_a.push_back(32'h0);
        wait_exec(32'h0);
        ack_delay = 6;
        br_taken = 1'b1; br_target = 32'h42;
        @(negedge clk);
        br_taken = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk("align_halted", halted, 1);
        chk("align_err_set", align_err, 1);
        chk("align_pc", pc, 32'h0);
        chk("align_no_req", imem_req, 0);
        chk("align_count", fetch_count, 1);
`else
        chk("align_req", imem_req, 1);
        chk("align_masked_addr", imem_addr, 32'h40);
        chk("align_err_zero", align_err, 0);
        chk("align_not_halted", halted, 0);
`endif

        // Asynchronous reset in the middle of a request
        do_reset();
        chk("reset_clears_align_err", align_err, 0);
        for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
        chk("midreq_req_before", imem_req, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreq_req", imem_req, 0);
        chk("midreq_pc", pc, 0);
        chk("midreq_valid", instr_valid, 0);
        chk("midreq_halted", halted, 0);
        chk("midreq_count", fetch_count, 0);
        @(negedge clk);
        rst = 1'b1;
        ack_delay = 0;
        q_a.push_back(32'h0);
        #1;
        chk("release_idle_no_req", imem_req, 0);
        @(negedge clk);
        chk("release_req", imem_req, 1);
        chk("release_req_addr", imem_addr, 32'h0);
        wait_exec(32'h0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("final_halted", halted, 1);

        for (int i = 0; i < 100 && !w_done; i++) @(negedge clk);
        chk("wrap_done", w_done, 1);
        chk("scoreboard_a_empty", q_a.size(), 0);
        chk("scoreboard_w_empty", q_w.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
